// File: rtl/store_drain_buffer_pkg.sv
// Shared definitions for the store drain path: bus command encodings,
// default geometry, the store-entry record and the drain FSM states.
package store_drain_buffer_pkg;

  // proc2mem bus command encodings
  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_LOAD  = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;

  // Default geometry of the drain buffer
  localparam int SD_DEPTH_DEF  = 4;
  localparam int SD_ADDR_W_DEF = 64;
  localparam int SD_DATA_W_DEF = 64;

  // Drain FSM states
  localparam logic [0:0] SD_IDLE  = 1'b0;
  localparam logic [0:0] SD_ISSUE = 1'b1;

  // One buffered committed store at the default geometry
  typedef struct packed {
    logic                     valid;
    logic [SD_ADDR_W_DEF-1:0] addr;
    logic [SD_DATA_W_DEF-1:0] data;
  } sd_entry_t;

endpackage

// File: rtl/store_drain_buffer_sd_fwd_match.sv
// Youngest-match priority selector for load forwarding. Entries are scanned
// from oldest to youngest relative to the tail so the youngest match wins.
module sd_fwd_match
  import store_drain_buffer_pkg::*;
#(
  parameter int SD_DEPTH = SD_DEPTH_DEF,
  parameter int ADDR_W   = SD_ADDR_W_DEF,
  parameter int DATA_W   = SD_DATA_W_DEF,
  parameter int PTR_W    = $clog2(SD_DEPTH)
) (
  input  logic [SD_DEPTH-1:0] ent_valid,
  input  logic [ADDR_W-1:0]   ent_addr [SD_DEPTH],
  input  logic [DATA_W-1:0]   ent_data [SD_DEPTH],
  input  logic [PTR_W-1:0]    tail,
  input  logic [ADDR_W-1:0]   probe_addr,
  output logic                hit,
  output logic [DATA_W-1:0]   hit_data
);

  // Quadword compare: byte offset bits are masked off
  localparam logic [ADDR_W-1:0] QW_MASK = ~ADDR_W'(7);

  logic [PTR_W-1:0] idx;

  // Scan oldest-to-youngest (distance from tail decreasing); last match wins
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = SD_DEPTH - 1; i >= 0; i--) begin
      idx = tail - PTR_W'(i + 1);
      if (ent_valid[idx] && (((ent_addr[idx] ^ probe_addr) & QW_MASK) == '0)) begin
        hit      = 1'b1;
        hit_data = ent_data[idx];
      end else begin
        hit      = hit;
        hit_data = hit_data;
      end
    end
  end

endmodule

// File: rtl/store_drain_buffer.sv
// Store drain buffer: queues committed stores from the SQ, drains them to
// memory over proc2mem when granted, coalesces back-to-back stores to the
// same quadword, and forwards buffered data to younger loads.
module store_drain_buffer
  import store_drain_buffer_pkg::*;
#(
  parameter int SD_DEPTH = SD_DEPTH_DEF,
  parameter int ADDR_W   = SD_ADDR_W_DEF,
  parameter int DATA_W   = SD_DATA_W_DEF
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        st_in_valid,
  input  logic [ADDR_W-1:0]           st_in_addr,
  input  logic [DATA_W-1:0]           st_in_data,
  output logic                        st_in_ready,
  input  logic                        mem_grant,
  output logic [1:0]                  proc2mem_command,
  output logic [ADDR_W-1:0]           proc2mem_addr,
  output logic [DATA_W-1:0]           proc2mem_data,
  input  logic [3:0]                  mem2proc_response,
  input  logic [ADDR_W-1:0]           ld_probe_addr,
  output logic                        ld_probe_hit,
  output logic [DATA_W-1:0]           ld_probe_data,
  output logic                        sd_empty,
  output logic [$clog2(SD_DEPTH):0]   sd_count,
  output logic                        overflow_err
);

  localparam int PTR_W = $clog2(SD_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(SD_DEPTH);
  localparam logic [ADDR_W-1:0] QW_MASK  = ~ADDR_W'(7);

  logic [SD_DEPTH-1:0] ent_valid;
  logic [ADDR_W-1:0]   ent_addr [SD_DEPTH];
  logic [DATA_W-1:0]   ent_data [SD_DEPTH];
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [CNT_W-1:0]    count;
  logic [0:0]          state;
  logic                overflow;

  logic [PTR_W-1:0]    youngest;
  logic                issuing;
  logic                accept;
  logic                coalesce;
  logic                push;
  logic                drop;
  logic [CNT_W-1:0]    count_next;
  logic [0:0]          state_next;

  // Push/pop/coalesce decisions from registered state and this cycle's inputs
  always_comb begin
    youngest    = tail - PTR_ONE;
    issuing     = (state == SD_ISSUE);
    accept      = issuing && mem_grant && (mem2proc_response != 4'h0);
    st_in_ready = (count < CNT_FULL);
    // Never rewrite the head while it may be on the bus
    coalesce    = st_in_valid && (count != '0) && ent_valid[youngest] &&
                  (((ent_addr[youngest] ^ st_in_addr) & QW_MASK) == '0) &&
                  !(issuing && (youngest == head));
    push        = st_in_valid && !coalesce && st_in_ready;
    drop        = st_in_valid && !coalesce && !st_in_ready;
  end

  // Occupancy and drain FSM next-state
  always_comb begin
    case ({push, accept})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
    case (state)
      SD_IDLE: begin
        if (count != '0) state_next = SD_ISSUE;
        else             state_next = SD_IDLE;
      end
      SD_ISSUE: begin
        if (accept && (count_next == '0)) state_next = SD_IDLE;
        else                              state_next = SD_ISSUE;
      end
      default: state_next = SD_IDLE;
    endcase
  end

  // Control state: pointers, count, valid bits, FSM, sticky overflow
  always_ff @(posedge clock) begin
    if (reset) begin
      ent_valid <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      state     <= SD_IDLE;
      overflow  <= 1'b0;
    end else begin
      count <= count_next;
      state <= state_next;
      if (drop) overflow <= 1'b1;
      if (accept) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PTR_ONE;
      end
      if (push) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PTR_ONE;
      end
    end
  end

  // Entry payload storage; only valid-qualified entries are ever observed
  always_ff @(posedge clock) begin
    if (push) begin
      ent_addr[tail] <= st_in_addr;
      ent_data[tail] <= st_in_data;
    end else if (coalesce) begin
      ent_data[youngest] <= st_in_data;
    end
  end

  // Bus request is presented only while issuing and granted
  always_comb begin
    if (issuing && mem_grant) begin
      proc2mem_command = BUS_STORE;
      proc2mem_addr    = ent_addr[head];
      proc2mem_data    = ent_data[head];
    end else begin
      proc2mem_command = BUS_NONE;
      proc2mem_addr    = '0;
      proc2mem_data    = '0;
    end
  end

  // Status outputs
  always_comb begin
    sd_empty     = (count == '0);
    sd_count     = count;
    overflow_err = overflow;
  end

  sd_fwd_match #(
    .SD_DEPTH (SD_DEPTH),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .PTR_W    (PTR_W)
  ) u_fwd_match (
    .ent_valid  (ent_valid),
    .ent_addr   (ent_addr),
    .ent_data   (ent_data),
    .tail       (tail),
    .probe_addr (ld_probe_addr),
    .hit        (ld_probe_hit),
    .hit_data   (ld_probe_data)
  );

endmodule

// File: tb/tb_store_drain_buffer.sv
// Directed self-checking bench for store_drain_buffer (SD_DEPTH=4).
module tb_store_drain_buffer;
  import store_drain_buffer_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        st_in_valid;
  logic [63:0] st_in_addr;
  logic [63:0] st_in_data;
  logic        st_in_ready;
  logic        mem_grant;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;
  logic [63:0] ld_probe_addr;
  logic        ld_probe_hit;
  logic [63:0] ld_probe_data;
  logic        sd_empty;
  logic [2:0]  sd_count;
  logic        overflow_err;

  int n_cmp = 0;
  int n_bad = 0;

  store_drain_buffer #(.SD_DEPTH(4), .ADDR_W(64), .DATA_W(64)) dut (
    .clock             (clock),
    .reset             (reset),
    .st_in_valid       (st_in_valid),
    .st_in_addr        (st_in_addr),
    .st_in_data        (st_in_data),
    .st_in_ready       (st_in_ready),
    .mem_grant         (mem_grant),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .mem2proc_response (mem2proc_response),
    .ld_probe_addr     (ld_probe_addr),
    .ld_probe_hit      (ld_probe_hit),
    .ld_probe_data     (ld_probe_data),
    .sd_empty          (sd_empty),
    .sd_count          (sd_count),
    .overflow_err      (overflow_err)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [63:0] a, input logic [63:0] d);
    st_in_valid = 1'b1;
    st_in_addr  = a;
    st_in_data  = d;
    tick();
    st_in_valid = 1'b0;
  endtask

  task automatic probe(input logic [63:0] a);
    ld_probe_addr = a;
    #1;
  endtask

  int pushed;
  int popped;

  initial begin
    reset = 1'b1; st_in_valid = 1'b0; st_in_addr = '0; st_in_data = '0;
    mem_grant = 1'b0; mem2proc_response = 4'h0; ld_probe_addr = '0;
    tick(); tick();
    check_eq("rst_cmd",   64'(proc2mem_command), 64'(BUS_NONE));
    check_eq("rst_addr",  proc2mem_addr, 64'h0);
    check_eq("rst_data",  proc2mem_data, 64'h0);
    check_eq("rst_hit",   64'(ld_probe_hit), 64'h0);
    check_eq("rst_empty", 64'(sd_empty), 64'h1);
    check_eq("rst_ready", 64'(st_in_ready), 64'h1);
    check_eq("rst_count", 64'(sd_count), 64'h0);
    check_eq("rst_ovf",   64'(overflow_err), 64'h0);
    reset = 1'b0;

    // Single store: command appears two cycles after the push
    mem_grant = 1'b1; mem2proc_response = 4'h1;
    push(64'h1000, 64'hDEAD);
    probe(64'h1004);
    check_eq("single_n1_cmd",  64'(proc2mem_command), 64'(BUS_NONE));
    check_eq("single_n1_hit",  64'(ld_probe_hit), 64'h1);
    check_eq("single_n1_fwd",  ld_probe_data, 64'hDEAD);
    tick();
    check_eq("single_n2_cmd",  64'(proc2mem_command), 64'(BUS_STORE));
    check_eq("single_n2_addr", proc2mem_addr, 64'h1000);
    check_eq("single_n2_data", proc2mem_data, 64'hDEAD);
    tick();
    check_eq("single_n3_cmd",  64'(proc2mem_command), 64'(BUS_NONE));
    check_eq("single_n3_empty", 64'(sd_empty), 64'h1);

    // Backpressure, coalesce-when-full, overflow, held head
    mem_grant = 1'b0; mem2proc_response = 4'h0;
    push(64'h5000, 64'h1);
    push(64'h5008, 64'h2);
    push(64'h5010, 64'h3);
    push(64'h5018, 64'h4);
    check_eq("bp_count", 64'(sd_count), 64'h4);
    check_eq("bp_ready", 64'(st_in_ready), 64'h0);
    push(64'h5018, 64'h44);
    probe(64'h5018);
    check_eq("bp_coal_count", 64'(sd_count), 64'h4);
    check_eq("bp_coal_ovf",   64'(overflow_err), 64'h0);
    check_eq("bp_coal_fwd",   ld_probe_data, 64'h44);
    push(64'h5020, 64'h5);
    probe(64'h5020);
    check_eq("bp_ovf",       64'(overflow_err), 64'h1);
    check_eq("bp_ovf_count", 64'(sd_count), 64'h4);
    check_eq("bp_drop_hit",  64'(ld_probe_hit), 64'h0);
    mem_grant = 1'b1; #1;
    for (int k = 0; k < 4; k++) begin
      check_eq("bp_hold_cmd",  64'(proc2mem_command), 64'(BUS_STORE));
      check_eq("bp_hold_addr", proc2mem_addr, 64'h5000);
      check_eq("bp_hold_data", proc2mem_data, 64'h1);
      tick();
    end
    mem2proc_response = 4'h2; #1;
    check_eq("bp_acc_addr", proc2mem_addr, 64'h5000);
    tick();
    mem2proc_response = 4'h0; #1;
    check_eq("bp_after_count", 64'(sd_count), 64'h3);
    check_eq("bp_next_addr",   proc2mem_addr, 64'h5008);
    check_eq("bp_next_data",   proc2mem_data, 64'h2);
    mem2proc_response = 4'h1;
    tick(); tick(); tick();
    check_eq("bp_drained", 64'(sd_empty), 64'h1);

    // Coalesce behind a stalled head on another address
    mem_grant = 1'b0; mem2proc_response = 4'h0;
    push(64'h6000, 64'h99);
    push(64'h2000, 64'h11);
    push(64'h2004, 64'h22);
    probe(64'h2000);
    check_eq("coal_count", 64'(sd_count), 64'h2);
    check_eq("coal_fwd",   ld_probe_data, 64'h22);
    mem_grant = 1'b1; mem2proc_response = 4'h1; #1;
    check_eq("coal_d0_addr", proc2mem_addr, 64'h6000);
    tick();
    check_eq("coal_d1_addr", proc2mem_addr, 64'h2000);
    check_eq("coal_d1_data", proc2mem_data, 64'h22);
    tick();
    check_eq("coal_done", 64'(sd_count), 64'h0);

    // No coalesce into the head while issuing
    mem_grant = 1'b0; mem2proc_response = 4'h0;
    push(64'h7000, 64'h33);
    tick();
    push(64'h7000, 64'h44);
    probe(64'h7000);
    check_eq("nocoal_count", 64'(sd_count), 64'h2);
    check_eq("nocoal_fwd",   ld_probe_data, 64'h44);
    mem_grant = 1'b1; mem2proc_response = 4'h1; #1;
    check_eq("nocoal_d0_data", proc2mem_data, 64'h33);
    tick();
    check_eq("nocoal_d1_data", proc2mem_data, 64'h44);
    tick();
    check_eq("nocoal_done", 64'(sd_count), 64'h0);

    // Forwarding: youngest match wins
    mem_grant = 1'b0; mem2proc_response = 4'h0;
    push(64'h3000, 64'hA);
    push(64'h3008, 64'hB);
    push(64'h3000, 64'hC);
    check_eq("fwd_count", 64'(sd_count), 64'h3);
    probe(64'h3003);
    check_eq("fwd_hit",  64'(ld_probe_hit), 64'h1);
    check_eq("fwd_data", ld_probe_data, 64'hC);
    probe(64'h4000);
    check_eq("fwd_miss_hit",  64'(ld_probe_hit), 64'h0);
    check_eq("fwd_miss_data", ld_probe_data, 64'h0);
    mem_grant = 1'b1; mem2proc_response = 4'h1;
    tick();
    probe(64'h3008);
    check_eq("fwd_pop_addr", proc2mem_addr, 64'h3008);
    check_eq("fwd_pop_hit",  64'(ld_probe_hit), 64'h1);
    check_eq("fwd_pop_data", ld_probe_data, 64'hB);
    tick(); tick();
    check_eq("fwd_done", 64'(sd_count), 64'h0);

    // Wrap-around: 10 pushes interleaved with pops, in-order delivery
    pushed = 0; popped = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      st_in_valid = ((cyc % 2) == 0) && (pushed < 10);
      st_in_addr  = 64'h8000 + 64'(pushed) * 64'h8;
      st_in_data  = 64'h100 + 64'(pushed);
      #1;
      if (proc2mem_command == BUS_STORE) begin
        check_eq("wrap_addr", proc2mem_addr, 64'h8000 + 64'(popped) * 64'h8);
        check_eq("wrap_data", proc2mem_data, 64'h100 + 64'(popped));
        popped++;
      end
      if (st_in_valid) pushed++;
      tick();
    end
    st_in_valid = 1'b0;
    check_eq("wrap_total", 64'(popped), 64'd10);
    check_eq("wrap_count", 64'(sd_count), 64'h0);

    // Reset while a store is on the bus
    mem_grant = 1'b0; mem2proc_response = 4'h0;
    push(64'h9000, 64'h77);
    tick();
    mem_grant = 1'b1; #1;
    check_eq("rmid_pending", 64'(proc2mem_command), 64'(BUS_STORE));
    check_eq("rmid_ovf_pre", 64'(overflow_err), 64'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    probe(64'h9000);
    check_eq("rmid_cmd",   64'(proc2mem_command), 64'(BUS_NONE));
    check_eq("rmid_count", 64'(sd_count), 64'h0);
    check_eq("rmid_ovf",   64'(overflow_err), 64'h0);
    check_eq("rmid_ready", 64'(st_in_ready), 64'h1);
    check_eq("rmid_hit",   64'(ld_probe_hit), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
